out_tx: RTL

Output-port transmitter for the SAP computer. It captures a byte from the W-bus when the output-load control is asserted and holds it as the parallel output register value. It then serialises that byte on a single line with start and stop framing, so an external receiver can read it. It sits at the end of the W-bus, beside the latch- and register-based storage blocks, which it reads from.

---
 rtl/out_tx.sv | 103 ++++++++++
 1 files changed

// File: rtl/out_tx.sv
// Output-port transmitter: latches a W-bus byte into OUT_REG on an active-low load
// and sends it as a start / WIDTH data bits LSB first / stop frame on TX.
module out_tx #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             CLR_BAR,
    input  logic [WIDTH-1:0] W_BUS,
    input  logic             LO_BAR,
    output logic [WIDTH-1:0] OUT_REG,
    output logic             TX,
    output logic             BUSY,
    output logic             DONE
);

    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(BIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [BIT_W-1:0] bit_cnt_reg;
    logic [CYC_W-1:0] cyc_cnt_reg;
    logic [WIDTH-1:0] shift_next;
    logic             bit_end;

    assign bit_end    = (cyc_cnt_reg == LAST_CYC);
    assign shift_next = shift_reg >> 1;

    always_ff @(posedge CLK or negedge CLR_BAR) begin
        if (!CLR_BAR) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            cyc_cnt_reg <= '0;
            OUT_REG     <= '0;
            TX          <= 1'b1;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // Loads are only honoured here; anything seen mid-frame is dropped.
                    if (!LO_BAR) begin
                        OUT_REG     <= W_BUS;
                        shift_reg   <= W_BUS;
                        bit_cnt_reg <= '0;
                        cyc_cnt_reg <= '0;
                        TX          <= 1'b0;
                        BUSY        <= 1'b1;
                        state_reg   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cyc_cnt_reg <= '0;
                        TX          <= shift_reg[0];
                        state_reg   <= DATA;
                    end else begin
                        cyc_cnt_reg <= cyc_cnt_reg + CYC_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cyc_cnt_reg <= '0;
                        if (bit_cnt_reg == LAST_BIT) begin
                            TX        <= 1'b1;
                            state_reg <= STOP;
                        end else begin
                            // TX is registered, so it takes the next LSB in the same edge.
                            bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                            shift_reg   <= shift_next;
                            TX          <= shift_next[0];
                        end
                    end else begin
                        cyc_cnt_reg <= cyc_cnt_reg + CYC_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cyc_cnt_reg <= '0;
                        BUSY        <= 1'b0;
                        DONE        <= 1'b1;
                        state_reg   <= IDLE;
                    end else begin
                        cyc_cnt_reg <= cyc_cnt_reg + CYC_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    TX        <= 1'b1;
                    BUSY      <= 1'b0;
                end
            endcase
        end
    end

endmodule
